// File: rtl/rtc_time_reader.sv
// Polls the PCF8563 time registers through the I2C register master and publishes
// a coherent {hour, minute, second} BCD word; also performs requested time-set writes.
module rtc_time_reader #(
  parameter int          POLL_CYCLES    = 5_000_000,
  parameter int          TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  DEV_ADDR       = 8'ha2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        i2c_read_req,
  output logic        i2c_write_req,
  output logic [7:0]  i2c_slave_dev_addr,
  output logic [7:0]  i2c_slave_reg_addr,
  output logic [7:0]  i2c_write_data,
  input  logic [7:0]  i2c_read_data,
  input  logic        i2c_read_req_ack,
  input  logic        i2c_write_req_ack,
  input  logic        set_time_en,
  input  logic [7:0]  set_hour,
  input  logic [7:0]  set_minute,
  input  logic [7:0]  set_second,
  output logic [23:0] rtc_data,
  output logic        rtc_valid,
  output logic        rtc_err,
  output logic        busy
);

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] WD_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, RD_SEC, RD_MIN, RD_HOUR, CHECK, WR_SEC, WR_MIN, WR_HOUR, GAP
  } state_t;

  state_t        state_q, state_d, after_gap_q, after_gap_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [TW-1:0] wd_q, wd_d;
  logic          rd_req_q, rd_req_d, wr_req_q, wr_req_d;
  logic [7:0]    reg_addr_q, reg_addr_d, wdata_q, wdata_d;
  logic          pending_q, pending_d;
  logic [23:0]   rtc_data_q, rtc_data_d;
  logic          valid_q, valid_d, err_q, err_d, busy_q, busy_d;
  logic [7:0]    sh_sec_q, sh_sec_d, sh_min_q, sh_min_d, sh_hour_q, sh_hour_d;
  logic [7:0]    hold_sec_q, hold_sec_d, hold_min_q, hold_min_d, hold_hour_q, hold_hour_d;
  logic          ack_rd, ack_wr, timeout;

  function automatic logic bcd_ok(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
    return (s[3:0] <= 4'd9) && (s[7:4] <= 4'd5) &&
           (m[3:0] <= 4'd9) && (m[7:4] <= 4'd5) &&
           (h[3:0] <= 4'd9) && (h <= 8'h23);
  endfunction

  always_comb begin
    state_d     = state_q;
    after_gap_d = after_gap_q;
    poll_d      = poll_q;
    wd_d        = wd_q;
    rd_req_d    = rd_req_q;
    wr_req_d    = wr_req_q;
    reg_addr_d  = reg_addr_q;
    wdata_d     = wdata_q;
    pending_d   = pending_q;
    rtc_data_d  = rtc_data_q;
    valid_d     = valid_q;
    err_d       = err_q;
    sh_sec_d    = sh_sec_q;
    sh_min_d    = sh_min_q;
    sh_hour_d   = sh_hour_q;
    hold_sec_d  = hold_sec_q;
    hold_min_d  = hold_min_q;
    hold_hour_d = hold_hour_q;

    // Simultaneous acks, or acks with no matching request outstanding, are ignored.
    ack_rd  = i2c_read_req_ack & ~i2c_write_req_ack & rd_req_q;
    ack_wr  = i2c_write_req_ack & ~i2c_read_req_ack & wr_req_q;
    timeout = (rd_req_q | wr_req_q) & ~ack_rd & ~ack_wr & (wd_q == WD_LAST);
    if (rd_req_q | wr_req_q) wd_d = wd_q + TW'(1);

    if (set_time_en) begin
      pending_d   = 1'b1;
      hold_sec_d  = set_second;
      hold_min_d  = set_minute;
      hold_hour_d = set_hour;
    end

    unique case (state_q)
      IDLE: begin
        if (poll_q == POLL_LAST) begin
          poll_d  = '0;
          state_d = pending_q ? WR_SEC : RD_SEC;
        end else begin
          poll_d = poll_q + PW'(1);
        end
      end
      RD_SEC, RD_MIN, RD_HOUR: begin
        if (ack_rd) begin
          rd_req_d = 1'b0;
          state_d  = GAP;
          if (state_q == RD_SEC) begin
            sh_sec_d    = i2c_read_data & 8'h7f;
            after_gap_d = RD_MIN;
          end else if (state_q == RD_MIN) begin
            sh_min_d    = i2c_read_data & 8'h7f;
            after_gap_d = RD_HOUR;
          end else begin
            sh_hour_d   = i2c_read_data & 8'h3f;
            after_gap_d = CHECK;
          end
        end else if (timeout) begin
          rd_req_d = 1'b0;
          err_d    = 1'b1;
          poll_d   = '0;
          state_d  = IDLE;
        end
      end
      WR_SEC, WR_MIN, WR_HOUR: begin
        if (ack_wr) begin
          wr_req_d = 1'b0;
          state_d  = GAP;
          if (state_q == WR_SEC) after_gap_d = WR_MIN;
          else if (state_q == WR_MIN) after_gap_d = WR_HOUR;
          else begin
            after_gap_d = RD_SEC;
            if (!set_time_en) pending_d = 1'b0;
          end
        end else if (timeout) begin
          wr_req_d = 1'b0;
          err_d    = 1'b1;
          poll_d   = '0;
          state_d  = IDLE;
        end
      end
      GAP: state_d = after_gap_q;
      CHECK: begin
        if (bcd_ok(sh_sec_q, sh_min_q, sh_hour_q)) begin
          rtc_data_d = {sh_hour_q, sh_min_q, sh_sec_q};
          valid_d    = 1'b1;
          err_d      = 1'b0;
        end else begin
          err_d = 1'b1;
        end
        poll_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Request and address are launched in the same edge that enters a transaction.
    if (state_d != state_q) begin
      unique case (state_d)
        RD_SEC:  begin rd_req_d = 1'b1; reg_addr_d = 8'h02; wd_d = '0; end
        RD_MIN:  begin rd_req_d = 1'b1; reg_addr_d = 8'h03; wd_d = '0; end
        RD_HOUR: begin rd_req_d = 1'b1; reg_addr_d = 8'h04; wd_d = '0; end
        WR_SEC:  begin wr_req_d = 1'b1; reg_addr_d = 8'h02; wd_d = '0; wdata_d = hold_sec_d & 8'h7f; end
        WR_MIN:  begin wr_req_d = 1'b1; reg_addr_d = 8'h03; wd_d = '0; wdata_d = hold_min_d; end
        WR_HOUR: begin wr_req_d = 1'b1; reg_addr_d = 8'h04; wd_d = '0; wdata_d = hold_hour_d; end
        default: ;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      after_gap_q <= IDLE;
      poll_q      <= POLL_LAST;
      wd_q        <= '0;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      reg_addr_q  <= 8'h00;
      wdata_q     <= 8'h00;
      pending_q   <= 1'b0;
      rtc_data_q  <= 24'h000000;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      after_gap_q <= after_gap_d;
      poll_q      <= poll_d;
      wd_q        <= wd_d;
      rd_req_q    <= rd_req_d;
      wr_req_q    <= wr_req_d;
      reg_addr_q  <= reg_addr_d;
      wdata_q     <= wdata_d;
      pending_q   <= pending_d;
      rtc_data_q  <= rtc_data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  // Shadow and holding bytes are pure data; they are always rewritten before use.
  always_ff @(posedge clk) begin
    sh_sec_q    <= sh_sec_d;
    sh_min_q    <= sh_min_d;
    sh_hour_q   <= sh_hour_d;
    hold_sec_q  <= hold_sec_d;
    hold_min_q  <= hold_min_d;
    hold_hour_q <= hold_hour_d;
  end

  assign i2c_read_req       = rd_req_q;
  assign i2c_write_req      = wr_req_q;
  assign i2c_slave_dev_addr = DEV_ADDR;
  assign i2c_slave_reg_addr = reg_addr_q;
  assign i2c_write_data     = wdata_q;
  assign rtc_data           = rtc_data_q;
  assign rtc_valid          = valid_q;
  assign rtc_err            = err_q;
  assign busy               = busy_q;

endmodule
